dac_mode_sequencer: RTL and testbench

Control-plane sequencer that sits between the PS register map and `DAC_Interface`. It arbitrates the run-mode requests (pseudo-random seed commit, triangle wave, PWL playback, halt) and guarantees that every mode switch first halts the active generator. It then waits for DAC readiness and restarts the new generator with a one-cycle reset. It also owns the active seed bank, so seeds are only ever swapped while the DAC is halted.

---
 rtl/dac_mode_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_dac_mode_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dac_mode_sequencer.sv
// rtl/dac_mode_sequencer.sv - DAC run-mode arbiter: halt, arm, restart, seed bank ownership
// Optional seed-completeness check on commit: DAC_SEQ_SEED_CHECK_EN
module dac_mode_sequencer #(
    parameter int NUM_SEEDS   = 16,
    parameter int SEED_WIDTH  = 16,
    parameter int HALT_CYCLES = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             seed_wr,
    input  logic [$clog2(NUM_SEEDS)-1:0]     seed_idx,
    input  logic [SEED_WIDTH-1:0]            seed_data,
    input  logic                             seed_commit,
    input  logic                             trig_req,
    input  logic                             pwl_req,
    input  logic                             pwl_loaded,
    input  logic                             halt_req,
    input  logic                             dac_rdy,
    output logic [NUM_SEEDS*SEED_WIDTH-1:0]  seeds,
    output logic [1:0]                       mode,
    output logic                             gen_rst,
    output logic                             halt,
    output logic                             cmd_ack,
    output logic                             cmd_err,
    output logic                             busy
);

    localparam int CNT_W = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HALT_LAST = CNT_W'(HALT_CYCLES - 1);

    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_RAND = 2'd1;
    localparam logic [1:0] MODE_TRIG = 2'd2;
    localparam logic [1:0] MODE_PWL  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_HALT, S_ARM, S_RUN} state_t;

    state_t                                r_state;
    state_t                                w_state_next;
    logic [1:0]                            r_pending;
    logic [1:0]                            w_pending_next;
    logic [CNT_W-1:0]                      r_cnt;
    logic [CNT_W-1:0]                      w_cnt_next;
    logic [1:0]                            r_mode;
    logic [1:0]                            w_mode_next;
    logic                                  r_gen_rst;
    logic                                  w_gen_rst_next;
    logic                                  r_halt;
    logic                                  w_halt_next;
    logic                                  r_cmd_ack;
    logic                                  r_cmd_err;
    logic                                  w_copy;

    logic [NUM_SEEDS-1:0][SEED_WIDTH-1:0]  r_shadow;
    logic [NUM_SEEDS-1:0][SEED_WIDTH-1:0]  w_shadow_next;
    logic [NUM_SEEDS-1:0][SEED_WIDTH-1:0]  r_seeds;

    logic                                  w_sel_halt;
    logic                                  w_sel_pwl;
    logic                                  w_sel_trig;
    logic                                  w_sel_commit;
    logic                                  w_pwl_ok;
    logic                                  w_commit_ok;
    logic                                  w_seeds_full;
    logic                                  w_mode_acc;
    logic [1:0]                            w_req_mode;
    logic                                  w_ack;
    logic                                  w_err;

    // Same-cycle write lands before any commit copy, so copies use the next shadow.
    always_comb begin
        w_shadow_next = r_shadow;
        if (seed_wr) begin
            w_shadow_next[seed_idx] = seed_data;
        end
    end

`ifdef DAC_SEQ_SEED_CHECK_EN
    logic [NUM_SEEDS-1:0] r_seed_mask;
    logic [NUM_SEEDS-1:0] w_mask_next;

    always_comb begin
        w_mask_next = r_seed_mask;
        if (seed_wr) begin
            w_mask_next[seed_idx] = 1'b1;
        end
    end

    assign w_seeds_full = &w_mask_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seed_mask <= '0;
        end else if (w_commit_ok) begin
            r_seed_mask <= '0;
        end else begin
            r_seed_mask <= w_mask_next;
        end
    end
`else
    assign w_seeds_full = 1'b1;
`endif

    // Fixed priority halt > pwl > trig > commit; losers are dropped silently.
    assign w_sel_halt   = halt_req;
    assign w_sel_pwl    = !halt_req && pwl_req;
    assign w_sel_trig   = !halt_req && !pwl_req && trig_req;
    assign w_sel_commit = !halt_req && !pwl_req && !trig_req && seed_commit;
    assign w_pwl_ok     = w_sel_pwl && pwl_loaded;
    assign w_commit_ok  = w_sel_commit && w_seeds_full;
    assign w_mode_acc   = w_pwl_ok || w_sel_trig || w_commit_ok;
    assign w_req_mode   = w_pwl_ok ? MODE_PWL : (w_sel_trig ? MODE_TRIG : MODE_RAND);
    assign w_ack        = w_sel_halt || w_mode_acc;
    assign w_err        = (w_sel_pwl && !pwl_loaded) || (w_sel_commit && !w_seeds_full);

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_cnt_next     = r_cnt;
        w_mode_next    = r_mode;
        w_gen_rst_next = 1'b0;
        w_halt_next    = 1'b0;
        if (w_mode_acc) begin
            w_pending_next = w_req_mode;
        end
        case (r_state)
            S_IDLE: begin
                if (w_sel_halt) begin
                    w_halt_next = 1'b1;
                end else if (w_mode_acc) begin
                    w_state_next = S_ARM;
                end
            end
            S_HALT: begin
                if (w_sel_halt) begin
                    w_cnt_next     = HALT_LAST;
                    w_pending_next = MODE_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_next = (w_pending_next != MODE_IDLE) ? S_ARM : S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_ARM: begin
                if (w_sel_halt) begin
                    w_state_next   = S_HALT;
                    w_pending_next = MODE_IDLE;
                    w_cnt_next     = HALT_LAST;
                    w_halt_next    = 1'b1;
                end else if (dac_rdy) begin
                    w_state_next   = S_RUN;
                    w_mode_next    = w_pending_next;
                    w_gen_rst_next = 1'b1;
                    w_pending_next = MODE_IDLE;
                end
            end
            S_RUN: begin
                if (w_sel_halt || w_mode_acc) begin
                    w_state_next = S_HALT;
                    w_cnt_next   = HALT_LAST;
                    w_halt_next  = 1'b1;
                    w_mode_next  = MODE_IDLE;
                    if (w_sel_halt) begin
                        w_pending_next = MODE_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Seeds swap only while halted: on ARM entry, or a commit landing while already armed.
    assign w_copy = ((r_state != S_ARM) && (w_state_next == S_ARM) && (w_pending_next == MODE_RAND))
                 || ((r_state == S_ARM) && w_commit_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pending <= MODE_IDLE;
            r_cnt     <= '0;
            r_mode    <= MODE_IDLE;
            r_gen_rst <= 1'b0;
            r_halt    <= 1'b0;
            r_cmd_ack <= 1'b0;
            r_cmd_err <= 1'b0;
            r_shadow  <= '0;
            r_seeds   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            r_cnt     <= w_cnt_next;
            r_mode    <= w_mode_next;
            r_gen_rst <= w_gen_rst_next;
            r_halt    <= w_halt_next;
            r_cmd_ack <= w_ack;
            r_cmd_err <= w_err;
            r_shadow  <= w_shadow_next;
            if (w_copy) begin
                r_seeds <= w_shadow_next;
            end
        end
    end

    assign seeds   = r_seeds;
    assign mode    = r_mode;
    assign gen_rst = r_gen_rst;
    assign halt    = r_halt;
    assign cmd_ack = r_cmd_ack;
    assign cmd_err = r_cmd_err;
    assign busy    = (r_state == S_HALT) || (r_state == S_ARM);

endmodule

// File: tb/tb_dac_mode_sequencer.sv
// tb/tb_dac_mode_sequencer.sv - vector table and scoreboard bench for dac_mode_sequencer
module tb_dac_mode_sequencer;

    localparam logic [5:0] R_CMT  = 6'b000001;
    localparam logic [5:0] R_TRIG = 6'b000010;
    localparam logic [5:0] R_LD   = 6'b000100;
    localparam logic [5:0] R_PWL  = 6'b001000;
    localparam logic [5:0] R_HALT = 6'b010000;
    localparam logic [5:0] R_RST  = 6'b100000;

    localparam logic [4:0] O_GEN  = 5'b10000;
    localparam logic [4:0] O_HALT = 5'b01000;
    localparam logic [4:0] O_ACK  = 5'b00100;
    localparam logic [4:0] O_ERR  = 5'b00010;
    localparam logic [4:0] O_BUSY = 5'b00001;

    typedef struct {
        string       name;
        logic [5:0]  rq;
        logic        rdy;
        logic        wr;
        logic [3:0]  idx;
        logic [15:0] data;
        logic [1:0]  e_mode;
        logic [4:0]  e_out;
        logic        chk_seeds;
        logic [15:0] seed_base;
        logic        seed_inc;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         seed_wr;
    logic [3:0]   seed_idx;
    logic [15:0]  seed_data;
    logic         seed_commit;
    logic         trig_req;
    logic         pwl_req;
    logic         pwl_loaded;
    logic         halt_req;
    logic         dac_rdy;
    logic [255:0] seeds;
    logic [1:0]   mode;
    logic         gen_rst;
    logic         halt;
    logic         cmd_ack;
    logic         cmd_err;
    logic         busy;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    dac_mode_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .seed_wr     (seed_wr),
        .seed_idx    (seed_idx),
        .seed_data   (seed_data),
        .seed_commit (seed_commit),
        .trig_req    (trig_req),
        .pwl_req     (pwl_req),
        .pwl_loaded  (pwl_loaded),
        .halt_req    (halt_req),
        .dac_rdy     (dac_rdy),
        .seeds       (seeds),
        .mode        (mode),
        .gen_rst     (gen_rst),
        .halt        (halt),
        .cmd_ack     (cmd_ack),
        .cmd_err     (cmd_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic add(input string nm, input logic [5:0] rq, input logic rdy,
                       input logic [1:0] m, input logic [4:0] o);
        vec_t v;
        v.name      = nm;
        v.rq        = rq;
        v.rdy       = rdy;
        v.wr        = 1'b0;
        v.idx       = 4'd0;
        v.data      = 16'd0;
        v.e_mode    = m;
        v.e_out     = o;
        v.chk_seeds = 1'b0;
        v.seed_base = 16'd0;
        v.seed_inc  = 1'b0;
        tbl.push_back(v);
    endtask

    task automatic wr_last(input logic [3:0] idx, input logic [15:0] data);
        tbl[tbl.size()-1].wr   = 1'b1;
        tbl[tbl.size()-1].idx  = idx;
        tbl[tbl.size()-1].data = data;
    endtask

    task automatic chk_last(input logic [15:0] base, input logic inc);
        tbl[tbl.size()-1].chk_seeds = 1'b1;
        tbl[tbl.size()-1].seed_base = base;
        tbl[tbl.size()-1].seed_inc  = inc;
    endtask

    task automatic add_busy(input string nm, input int n, input logic rdy);
        for (int k = 0; k < n; k++) add(nm, 6'b0, rdy, 2'd0, O_BUSY);
    endtask

    task automatic run_vec(input vec_t v);
        vec_t        e;
        logic [6:0]  act;
        logic [6:0]  expv;
        logic [15:0] w;
        logic [15:0] ew;
        @(negedge clk);
        seed_commit = v.rq[0];
        trig_req    = v.rq[1];
        pwl_loaded  = v.rq[2];
        pwl_req     = v.rq[3];
        halt_req    = v.rq[4];
        rst         = v.rq[5];
        dac_rdy     = v.rdy;
        seed_wr     = v.wr;
        seed_idx    = v.idx;
        seed_data   = v.data;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e    = exp_q.pop_front();
        act  = {mode, gen_rst, halt, cmd_ack, cmd_err, busy};
        expv = {e.e_mode, e.e_out};
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: mode,gen_rst,halt,ack,err,busy got %b required %b", e.name, act, expv);
        end
        if (e.chk_seeds) begin
            for (int i = 0; i < 16; i++) begin
                w  = seeds[i*16 +: 16];
                ew = e.seed_base + (e.seed_inc ? 16'(i) : 16'd0);
                n_vec++;
                if (w !== ew) begin
                    n_err++;
                    $display("FAIL %s seed[%0d]: got %h required %h", e.name, i, w, ew);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; seed_wr = 1'b0; seed_idx = 4'd0; seed_data = 16'd0;
        seed_commit = 1'b0; trig_req = 1'b0; pwl_req = 1'b0;
        pwl_loaded = 1'b0; halt_req = 1'b0; dac_rdy = 1'b0;

        add("reset", R_RST, 1'b1, 2'd0, 5'b0);
        chk_last(16'h0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            add("seed_wr", 6'b0, 1'b1, 2'd0, 5'b0);
            wr_last(4'(i), 16'hBEEF + 16'(i));
        end
`ifdef DAC_SEQ_SEED_CHECK_EN
        add("commit_15_of_16", R_CMT, 1'b1, 2'd0, O_ERR);
        chk_last(16'h0, 1'b0);
`endif
        add("commit_idle", R_CMT, 1'b1, 2'd0, O_ACK | O_BUSY);
        wr_last(4'd15, 16'hBEEF + 16'd15);
        add("rand_run", 6'b0, 1'b1, 2'd1, O_GEN);
        chk_last(16'hBEEF, 1'b1);
        add("rand_hold", 6'b0, 1'b1, 2'd1, 5'b0);

        add("preempt_trig", R_TRIG, 1'b1, 2'd0, O_HALT | O_ACK | O_BUSY);
        add_busy("preempt_halt", 3, 1'b1);
        add_busy("preempt_arm", 1, 1'b1);
        add("preempt_run", 6'b0, 1'b1, 2'd2, O_GEN);
        add("trig_hold", 6'b0, 1'b1, 2'd2, 5'b0);

        add("halt_beats_trig", R_HALT | R_TRIG, 1'b1, 2'd0, O_HALT | O_ACK | O_BUSY);
        add_busy("halt_window", 3, 1'b1);
        add("halt_to_idle", 6'b0, 1'b1, 2'd0, 5'b0);
        add("idle_quiet", 6'b0, 1'b1, 2'd0, 5'b0);
        add("halt_in_idle", R_HALT, 1'b1, 2'd0, O_HALT | O_ACK);

        add("stall_req", R_TRIG, 1'b0, 2'd0, O_ACK | O_BUSY);
        add_busy("arm_stall", 20, 1'b0);
        add("stall_release", 6'b0, 1'b1, 2'd2, O_GEN);

        add("pwl_unloaded", R_PWL | R_TRIG, 1'b1, 2'd2, O_ERR);
        add("after_reject", 6'b0, 1'b1, 2'd2, 5'b0);

        add("pwl_wins", R_PWL | R_LD | R_TRIG | R_CMT, 1'b1, 2'd0, O_HALT | O_ACK | O_BUSY);
        add_busy("pwl_halt", 3, 1'b1);
        add_busy("pwl_arm", 1, 1'b1);
        add("pwl_run", 6'b0, 1'b1, 2'd3, O_GEN);

        add("abort_req", R_TRIG, 1'b0, 2'd0, O_HALT | O_ACK | O_BUSY);
        add_busy("abort_halt_win", 3, 1'b0);
        add_busy("abort_arm", 2, 1'b0);
        add("abort_halt", R_HALT, 1'b0, 2'd0, O_HALT | O_ACK | O_BUSY);
        add_busy("abort_window", 3, 1'b0);
        add("abort_idle", 6'b0, 1'b0, 2'd0, 5'b0);

        add("trig_idle", R_TRIG, 1'b1, 2'd0, O_ACK | O_BUSY);
        add("trig_run", 6'b0, 1'b1, 2'd2, O_GEN);
        add("pre_reset_trig", R_TRIG, 1'b1, 2'd0, O_HALT | O_ACK | O_BUSY);
        add("reset_mid_halt", R_RST, 1'b1, 2'd0, 5'b0);
        chk_last(16'h0, 1'b0);
        add("post_reset_trig", R_TRIG, 1'b1, 2'd0, O_ACK | O_BUSY);
        add("post_reset_run", 6'b0, 1'b1, 2'd2, O_GEN);

`ifdef DAC_SEQ_SEED_CHECK_EN
        add("commit_no_seeds", R_CMT, 1'b1, 2'd2, O_ERR);
        chk_last(16'h0, 1'b0);
`else
        add("stale_commit", R_CMT, 1'b1, 2'd0, O_HALT | O_ACK | O_BUSY);
        add_busy("stale_halt", 3, 1'b1);
        add_busy("stale_arm", 1, 1'b1);
        add("stale_run", 6'b0, 1'b1, 2'd1, O_GEN);
        chk_last(16'h0, 1'b0);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
